threshold_monitor: RTL and testbench

Sequential consumer of a 4-bit magnitude comparator's three result flags (greater, lesser, equal), with sample compared against threshold. It debounces the comparison stream with a confirm-count state machine and produces a registered alarm level with rise/fall pulses. It also keeps a saturating event counter and a sticky flag-integrity error. It sits directly downstream of the comparator and feeds status/LED logic.

---
 rtl/threshold_monitor_pkg.sv | 19 +
 rtl/threshold_monitor_confirm_counter.sv | 41 ++++
 rtl/threshold_monitor.sv | 209 ++++++++++++++++++++
 tb/tb_threshold_monitor.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/threshold_monitor_pkg.sv
// Shared types and constants for the threshold monitor: FSM state encoding,
// default confirm count and run-counter width.
package threshold_monitor_pkg;

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        PEND_HIGH = 2'd1,
        HIGH      = 2'd2,
        PEND_LOW  = 2'd3
    } state_e;

    localparam int DEFAULT_CONFIRM_CNT = 3;
    localparam int RUN_W               = 4;

    function automatic logic isOneHot3(input logic a, input logic b, input logic c);
        return (a & ~b & ~c) | (~a & b & ~c) | (~a & ~b & c);
    endfunction

endpackage

// File: rtl/threshold_monitor_confirm_counter.sv
// Run counter for the debounce FSM: clear / load-to-one / increment, plus a
// terminal flag that says the current confirming sample completes the run.
module confirm_counter
    import threshold_monitor_pkg::*;
#(
    parameter int CONFIRM_CNT = DEFAULT_CONFIRM_CNT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic load_i,
    input  logic inc_i,
    output logic term_o
);

    logic [RUN_W-1:0] run_q;
    logic [RUN_W-1:0] run_d;

    always_comb begin
        run_d = run_q;
        if (clr_i) begin
            run_d = '0;
        end else if (load_i) begin
            run_d = RUN_W'(1);
        end else if (inc_i) begin
            run_d = run_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q <= '0;
        end else begin
            run_q <= run_d;
        end
    end

    // The FSM clears instead of incrementing on terminal, so run stays below CONFIRM_CNT.
    assign term_o = ((int'(run_q) + 1) == CONFIRM_CNT);

endmodule

// File: rtl/threshold_monitor.sv
// Debounced threshold alarm with rise/fall pulses, saturating rise counter and
// sticky flag-integrity error. Define THRESHOLD_MONITOR_PEAK_TRACK_EN for peak tracking.
module threshold_monitor
    import threshold_monitor_pkg::*;
#(
    parameter int CONFIRM_CNT = DEFAULT_CONFIRM_CNT,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmp_valid,
    input  logic             a_greater_b,
    input  logic             a_lesser_b,
    input  logic             a_equal_b,
    input  logic [3:0]       sample,
    input  logic             clear,
    output logic             alarm,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] event_count,
    output logic             flag_err,
    output logic [3:0]       peak
);

    logic accepted;
    logic above;
    logic badFlags;

    state_e state_q;
    state_e state_d;

    logic runTerm;
    logic runClr;
    logic runLoad;
    logic runInc;

    logic alarm_q, alarm_d;
    logic rise_q, rise_d;
    logic fall_q, fall_d;
    logic [CNT_W-1:0] eventCount_q, eventCount_d;
    logic flagErr_q, flagErr_d;

    assign accepted = cmp_valid & isOneHot3(a_greater_b, a_lesser_b, a_equal_b);
    assign badFlags = cmp_valid & ~isOneHot3(a_greater_b, a_lesser_b, a_equal_b);
    assign above    = a_greater_b;

    confirm_counter #(
        .CONFIRM_CNT(CONFIRM_CNT)
    ) u_confirm_counter (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (runClr),
        .load_i (runLoad),
        .inc_i  (runInc),
        .term_o (runTerm)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOW;
            alarm_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            alarm_q <= alarm_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Only accepted samples advance the FSM; invalid and malformed cycles leave run untouched.
    always_comb begin
        state_d = state_q;
        runClr  = 1'b0;
        runLoad = 1'b0;
        runInc  = 1'b0;
        if (accepted) begin
            case (state_q)
                LOW: begin
                    if (above) begin
                        if (runTerm) begin
                            state_d = HIGH;
                            runClr  = 1'b1;
                        end else begin
                            state_d = PEND_HIGH;
                            runLoad = 1'b1;
                        end
                    end else begin
                        runClr = 1'b1;
                    end
                end
                PEND_HIGH: begin
                    if (above) begin
                        if (runTerm) begin
                            state_d = HIGH;
                            runClr  = 1'b1;
                        end else begin
                            runInc = 1'b1;
                        end
                    end else begin
                        state_d = LOW;
                        runClr  = 1'b1;
                    end
                end
                HIGH: begin
                    if (!above) begin
                        if (runTerm) begin
                            state_d = LOW;
                            runClr  = 1'b1;
                        end else begin
                            state_d = PEND_LOW;
                            runLoad = 1'b1;
                        end
                    end else begin
                        runClr = 1'b1;
                    end
                end
                PEND_LOW: begin
                    if (!above) begin
                        if (runTerm) begin
                            state_d = LOW;
                            runClr  = 1'b1;
                        end else begin
                            runInc = 1'b1;
                        end
                    end else begin
                        state_d = HIGH;
                        runClr  = 1'b1;
                    end
                end
                default: begin
                    state_d = LOW;
                    runClr  = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        alarm_d = (state_d == HIGH) || (state_d == PEND_LOW);
        rise_d  = (state_d == HIGH) && ((state_q == LOW) || (state_q == PEND_HIGH));
        fall_d  = (state_d == LOW) && ((state_q == PEND_LOW) || (state_q == HIGH));
    end

    // Clear beats a coincident increment or error; the rise pulse itself is unaffected.
    always_comb begin
        eventCount_d = eventCount_q;
        flagErr_d    = flagErr_q;
        if (clear) begin
            eventCount_d = '0;
            flagErr_d    = 1'b0;
        end else begin
            if (rise_d && (eventCount_q != {CNT_W{1'b1}})) begin
                eventCount_d = eventCount_q + 1'b1;
            end
            if (badFlags) begin
                flagErr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            eventCount_q <= '0;
            flagErr_q    <= 1'b0;
        end else begin
            eventCount_q <= eventCount_d;
            flagErr_q    <= flagErr_d;
        end
    end

`ifdef THRESHOLD_MONITOR_PEAK_TRACK_EN
    logic [3:0] peak_q;
    logic [3:0] peak_d;

    always_comb begin
        peak_d = peak_q;
        if (clear) begin
            peak_d = 4'd0;
        end else if (rise_d) begin
            peak_d = sample;
        end else if (accepted && ((state_q == HIGH) || (state_q == PEND_LOW)) && (sample > peak_q)) begin
            peak_d = sample;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            peak_q <= 4'd0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak = peak_q;
`else
    logic unusedSample;
    assign unusedSample = ^sample;
    assign peak         = 4'd0;
`endif

    assign alarm       = alarm_q;
    assign rise_pulse  = rise_q;
    assign fall_pulse  = fall_q;
    assign event_count = eventCount_q;
    assign flag_err    = flagErr_q;

endmodule

// File: tb/tb_threshold_monitor.sv
// Scoreboard bench for threshold_monitor (CONFIRM_CNT=3, CNT_W=2): directed vectors
// push hand-computed expectations, a monitor pops and compares after each edge.
module tb_threshold_monitor;

    localparam int K_IDLE = 0;
    localparam int K_GT   = 1;
    localparam int K_LT   = 2;
    localparam int K_EQ   = 3;
    localparam int K_BAD2 = 4;
    localparam int K_BAD0 = 5;

    typedef struct {
        string      name;
        logic       alarm;
        logic       rise;
        logic       fall;
        logic [1:0] cnt;
        logic       err;
        logic [3:0] peak;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmpValid;
    logic       aGt;
    logic       aLt;
    logic       aEq;
    logic [3:0] sampleIn;
    logic       clearIn;
    logic       alarm;
    logic       risePulse;
    logic       fallPulse;
    logic [1:0] eventCount;
    logic       flagErr;
    logic [3:0] peak;

    exp_t expQ[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    threshold_monitor #(
        .CONFIRM_CNT(3),
        .CNT_W      (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmp_valid   (cmpValid),
        .a_greater_b (aGt),
        .a_lesser_b  (aLt),
        .a_equal_b   (aEq),
        .sample      (sampleIn),
        .clear       (clearIn),
        .alarm       (alarm),
        .rise_pulse  (risePulse),
        .fall_pulse  (fallPulse),
        .event_count (eventCount),
        .flag_err    (flagErr),
        .peak        (peak)
    );

    task automatic checkField(input string name, input string field, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("[TB] FAIL %s.%s got=%0d expected=%0d", name, field, got, want);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        checkField(e.name, "alarm", int'(alarm), int'(e.alarm));
        checkField(e.name, "rise_pulse", int'(risePulse), int'(e.rise));
        checkField(e.name, "fall_pulse", int'(fallPulse), int'(e.fall));
        checkField(e.name, "event_count", int'(eventCount), int'(e.cnt));
        checkField(e.name, "flag_err", int'(flagErr), int'(e.err));
        checkField(e.name, "peak", int'(peak), int'(e.peak));
    endtask

    task automatic applyStimulus(input string name, input int kind, input logic [3:0] smp,
                                 input logic clr, input logic rs,
                                 input logic eA, input logic eR, input logic eF,
                                 input logic [1:0] eC, input logic eE, input logic [3:0] ePeakOn);
        exp_t e;
        @(negedge clk);
        rst      = rs;
        clearIn  = clr;
        sampleIn = smp;
        cmpValid = (kind != K_IDLE);
        aGt      = (kind == K_GT) || (kind == K_BAD2);
        aLt      = (kind == K_LT) || (kind == K_BAD2);
        aEq      = (kind == K_EQ);
        e.name  = name;
        e.alarm = eA;
        e.rise  = eR;
        e.fall  = eF;
        e.cnt   = eC;
        e.err   = eE;
`ifdef THRESHOLD_MONITOR_PEAK_TRACK_EN
        e.peak  = ePeakOn;
`else
        e.peak  = 4'd0;
`endif
        expQ.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        int prevCnt;
        int newCnt;
        logic [3:0] peakBefore;
        int waitCycles;

        rst = 1'b1; cmpValid = 1'b0; aGt = 1'b0; aLt = 1'b0; aEq = 1'b0;
        sampleIn = 4'd0; clearIn = 1'b0;

        for (int i = 0; i < 2; i++) begin
            applyStimulus("reset", int'($urandom_range(0, 5)), 4'($urandom), 1'($urandom), 1'b1,
                          0, 0, 0, 2'd0, 0, 4'd0);
        end

        applyStimulus("rise1",    K_GT,   4'd5, 0, 0, 0, 0, 0, 2'd0, 0, 4'd0);
        applyStimulus("gapA",     K_IDLE, 4'd0, 0, 0, 0, 0, 0, 2'd0, 0, 4'd0);
        applyStimulus("gapB",     K_IDLE, 4'd0, 0, 0, 0, 0, 0, 2'd0, 0, 4'd0);
        applyStimulus("rise2",    K_GT,   4'd6, 0, 0, 0, 0, 0, 2'd0, 0, 4'd0);
        applyStimulus("rise3",    K_GT,   4'd7, 0, 0, 1, 1, 0, 2'd1, 0, 4'd7);
        applyStimulus("holdHigh", K_IDLE, 4'd0, 0, 0, 1, 0, 0, 2'd1, 0, 4'd7);
        applyStimulus("fall1",    K_LT,   4'd2, 0, 0, 1, 0, 0, 2'd1, 0, 4'd7);
        applyStimulus("fall2",    K_LT,   4'd2, 0, 0, 1, 0, 0, 2'd1, 0, 4'd7);
        applyStimulus("fall3",    K_LT,   4'd2, 0, 0, 0, 0, 1, 2'd1, 0, 4'd7);
        applyStimulus("holdLow",  K_IDLE, 4'd0, 0, 0, 0, 0, 0, 2'd1, 0, 4'd7);

        applyStimulus("dbGt1",    K_GT,   4'd1, 0, 0, 0, 0, 0, 2'd1, 0, 4'd7);
        applyStimulus("dbGt2",    K_GT,   4'd1, 0, 0, 0, 0, 0, 2'd1, 0, 4'd7);
        applyStimulus("dbEq",     K_EQ,   4'd3, 0, 0, 0, 0, 0, 2'd1, 0, 4'd7);
        applyStimulus("dbGt3",    K_GT,   4'd1, 0, 0, 0, 0, 0, 2'd1, 0, 4'd7);
        applyStimulus("dbGt4",    K_GT,   4'd1, 0, 0, 0, 0, 0, 2'd1, 0, 4'd7);
        applyStimulus("peakRise", K_GT,   4'd9, 0, 0, 1, 1, 0, 2'd2, 0, 4'd9);
        applyStimulus("peakMax",  K_GT,   4'd12, 0, 0, 1, 0, 0, 2'd2, 0, 4'd12);
        applyStimulus("peakEq",   K_EQ,   4'd7, 0, 0, 1, 0, 0, 2'd2, 0, 4'd12);
        applyStimulus("peakLt",   K_LT,   4'd0, 0, 0, 1, 0, 0, 2'd2, 0, 4'd12);
        applyStimulus("backHigh", K_GT,   4'd4, 0, 0, 1, 0, 0, 2'd2, 0, 4'd12);
        applyStimulus("fallB1",   K_LT,   4'd0, 0, 0, 1, 0, 0, 2'd2, 0, 4'd12);
        applyStimulus("fallB2",   K_LT,   4'd0, 0, 0, 1, 0, 0, 2'd2, 0, 4'd12);
        applyStimulus("fallB3",   K_LT,   4'd0, 0, 0, 0, 0, 1, 2'd2, 0, 4'd12);

        applyStimulus("errPend",  K_GT,   4'd10, 0, 0, 0, 0, 0, 2'd2, 0, 4'd12);
        applyStimulus("badFlags", K_BAD2, 4'd10, 0, 0, 0, 0, 0, 2'd2, 1, 4'd12);
        applyStimulus("errRun2",  K_GT,   4'd10, 0, 0, 0, 0, 0, 2'd2, 1, 4'd12);
        applyStimulus("errRise",  K_GT,   4'd10, 0, 0, 1, 1, 0, 2'd3, 1, 4'd10);
        applyStimulus("clear",    K_IDLE, 4'd0,  1, 0, 1, 0, 0, 2'd0, 0, 4'd0);
        applyStimulus("badNone",  K_BAD0, 4'd0,  0, 0, 1, 0, 0, 2'd0, 1, 4'd0);

        for (int k = 1; k <= 4; k++) begin
            prevCnt    = (k - 1 > 3) ? 3 : k - 1;
            newCnt     = (k > 3) ? 3 : k;
            peakBefore = (k == 1) ? 4'd0 : 4'd15;
            applyStimulus("satLt1", K_LT, 4'd0,  0, 0, 1, 0, 0, 2'(prevCnt), 1, peakBefore);
            applyStimulus("satLt2", K_LT, 4'd0,  0, 0, 1, 0, 0, 2'(prevCnt), 1, peakBefore);
            applyStimulus("satLt3", K_LT, 4'd0,  0, 0, 0, 0, 1, 2'(prevCnt), 1, peakBefore);
            applyStimulus("satGt1", K_GT, 4'd15, 0, 0, 0, 0, 0, 2'(prevCnt), 1, peakBefore);
            applyStimulus("satGt2", K_GT, 4'd15, 0, 0, 0, 0, 0, 2'(prevCnt), 1, peakBefore);
            applyStimulus("satRise", K_GT, 4'd15, 0, 0, 1, 1, 0, 2'(newCnt), 1, 4'd15);
        end

        applyStimulus("scLt1",    K_LT, 4'd0,  0, 0, 1, 0, 0, 2'd3, 1, 4'd15);
        applyStimulus("scLt2",    K_LT, 4'd0,  0, 0, 1, 0, 0, 2'd3, 1, 4'd15);
        applyStimulus("scLt3",    K_LT, 4'd0,  0, 0, 0, 0, 1, 2'd3, 1, 4'd15);
        applyStimulus("scGt1",    K_GT, 4'd15, 0, 0, 0, 0, 0, 2'd3, 1, 4'd15);
        applyStimulus("scGt2",    K_GT, 4'd15, 0, 0, 0, 0, 0, 2'd3, 1, 4'd15);
        applyStimulus("satClear", K_GT, 4'd15, 1, 0, 1, 1, 0, 2'd0, 0, 4'd0);

        applyStimulus("rstLt1",   K_LT,   4'd0, 0, 0, 1, 0, 0, 2'd0, 0, 4'd0);
        applyStimulus("rstLt2",   K_LT,   4'd0, 0, 0, 1, 0, 0, 2'd0, 0, 4'd0);
        applyStimulus("rstPulse", K_LT,   4'd0, 0, 1, 0, 0, 0, 2'd0, 0, 4'd0);
        applyStimulus("postRst",  K_IDLE, 4'd0, 0, 0, 0, 0, 0, 2'd0, 0, 4'd0);
        applyStimulus("prGt1",    K_GT,   4'd3, 0, 0, 0, 0, 0, 2'd0, 0, 4'd0);
        applyStimulus("prGt2",    K_GT,   4'd3, 0, 0, 0, 0, 0, 2'd0, 0, 4'd0);
        applyStimulus("prRise",   K_GT,   4'd3, 0, 0, 1, 1, 0, 2'd1, 0, 4'd3);
        applyStimulus("prHold",   K_IDLE, 4'd0, 0, 0, 1, 0, 0, 2'd1, 0, 4'd3);

        waitCycles = 0;
        while ((expQ.size() > 0) && (waitCycles < 10)) begin
            @(negedge clk);
            waitCycles++;
        end
        if (expQ.size() > 0) begin
            failures++;
            $display("[TB] FAIL drain pending=%0d expected=0", expQ.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
